// File: rtl/ir_queue_if.sv
// Handshake bundle between instruction fetch (master) and the ir_queue (slave).
// IR_PARITY_EN adds the parity error output and the error-injection input.
interface ir_queue_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 3
);
  logic [WIDTH-1:0] instructionIn;
  logic             IRWre;
  logic             IRPop;
  logic             IRFlush;
  logic [WIDTH-1:0] instructionOut;
  logic             irValid;
  logic             irFull;
  logic [CNT_W-1:0] irCount;
  logic             pushDrop;
`ifdef IR_PARITY_EN
  logic             irInjectErr;
  logic             irParityErr;

  modport master (
    output instructionIn, IRWre, IRPop, IRFlush, irInjectErr,
    input  instructionOut, irValid, irFull, irCount, pushDrop, irParityErr
  );
  modport slave (
    input  instructionIn, IRWre, IRPop, IRFlush, irInjectErr,
    output instructionOut, irValid, irFull, irCount, pushDrop, irParityErr
  );
`else
  modport master (
    output instructionIn, IRWre, IRPop, IRFlush,
    input  instructionOut, irValid, irFull, irCount, pushDrop
  );
  modport slave (
    input  instructionIn, IRWre, IRPop, IRFlush,
    output instructionOut, irValid, irFull, irCount, pushDrop
  );
`endif
endinterface

// File: rtl/ir_queue.sv
// Circular instruction queue replacing the single-entry IR; flushable on redirect.
// Optional macro IR_PARITY_EN adds a per-entry even-parity bit and irParityErr.
module ir_queue #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input logic       CLK,
  input logic       RST_N,
  ir_queue_if.slave irq
);
  localparam int PTR_W = $clog2(DEPTH);

  function automatic logic even_parity(input logic [WIDTH-1:0] word);
    even_parity = ^word;
  endfunction

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] cnt_r;
  logic             valid_r;
  logic             full_r;
  logic             drop_r;
  logic [WIDTH-1:0] head_r;

  logic             push_ok_s;
  logic             pop_ok_s;
  logic             drop_s;
  logic             bypass_s;
  logic [PTR_W-1:0] rd_nxt_s;
  logic [PTR_W-1:0] wr_nxt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [WIDTH-1:0] head_nxt_s;

`ifdef IR_PARITY_EN
  logic             par_mem_r [DEPTH];
  logic             par_err_r;
  logic             par_in_s;
  logic             par_head_s;
  logic             par_err_nxt_s;
`endif

  // Accept/reject decisions; flush overrides push and pop, pop needs a valid head.
  always_comb begin
    push_ok_s = 1'b0;
    pop_ok_s  = 1'b0;
    drop_s    = 1'b0;
    if (irq.IRFlush) begin
      push_ok_s = 1'b0;
      pop_ok_s  = 1'b0;
      drop_s    = 1'b0;
    end else begin
      push_ok_s = irq.IRWre && (!full_r || irq.IRPop);
      pop_ok_s  = irq.IRPop && valid_r;
      drop_s    = irq.IRWre && full_r && !irq.IRPop;
    end
  end

  // Next pointers and occupancy.
  always_comb begin
    rd_nxt_s  = rd_ptr_r;
    wr_nxt_s  = wr_ptr_r;
    cnt_nxt_s = cnt_r;
    if (irq.IRFlush) begin
      rd_nxt_s  = {PTR_W{1'b0}};
      wr_nxt_s  = {PTR_W{1'b0}};
      cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_nxt_s = wr_ptr_r + PTR_W'(1);
      end else begin
        wr_nxt_s = wr_ptr_r;
      end
      if (pop_ok_s) begin
        rd_nxt_s = rd_ptr_r + PTR_W'(1);
      end else begin
        rd_nxt_s = rd_ptr_r;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1);
        2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1);
        default: cnt_nxt_s = cnt_r;
      endcase
    end
  end

  // The new head is the word being written this cycle when the read pointer lands on the write slot.
  always_comb begin
    bypass_s = push_ok_s && (rd_nxt_s == wr_ptr_r);
    if (cnt_nxt_s == {CNT_W{1'b0}}) begin
      head_nxt_s = {WIDTH{1'b0}};
    end else if (bypass_s) begin
      head_nxt_s = irq.instructionIn;
    end else begin
      head_nxt_s = mem_r[rd_nxt_s];
    end
  end

  // Entry storage; contents need no reset because head/valid gate every read.
  always_ff @(posedge CLK) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= irq.instructionIn;
    end
  end

  // Pointer, count and registered output state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      valid_r  <= 1'b0;
      full_r   <= 1'b0;
      drop_r   <= 1'b0;
      head_r   <= {WIDTH{1'b0}};
    end else begin
      rd_ptr_r <= rd_nxt_s;
      wr_ptr_r <= wr_nxt_s;
      cnt_r    <= cnt_nxt_s;
      valid_r  <= (cnt_nxt_s != {CNT_W{1'b0}});
      full_r   <= (cnt_nxt_s == CNT_W'(DEPTH));
      drop_r   <= drop_s;
      head_r   <= head_nxt_s;
    end
  end

  assign irq.instructionOut = head_r;
  assign irq.irValid        = valid_r;
  assign irq.irFull         = full_r;
  assign irq.irCount        = cnt_r;
  assign irq.pushDrop       = drop_r;

`ifdef IR_PARITY_EN
  // Stored parity of the next head, inverted on injection, checked against the head word.
  always_comb begin
    par_in_s = even_parity(irq.instructionIn) ^ irq.irInjectErr;
    if (bypass_s) begin
      par_head_s = par_in_s;
    end else begin
      par_head_s = par_mem_r[rd_nxt_s];
    end
    if (cnt_nxt_s == {CNT_W{1'b0}}) begin
      par_err_nxt_s = 1'b0;
    end else begin
      par_err_nxt_s = (par_head_s != even_parity(head_nxt_s));
    end
  end

  // Parity bit storage alongside the entry storage.
  always_ff @(posedge CLK) begin
    if (push_ok_s) begin
      par_mem_r[wr_ptr_r] <= par_in_s;
    end
  end

  // Registered parity error flag.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      par_err_r <= 1'b0;
    end else begin
      par_err_r <= par_err_nxt_s;
    end
  end

  assign irq.irParityErr = par_err_r;
`endif

endmodule

// File: tb/tb_ir_queue.sv
// Directed self-checking bench for ir_queue (DEPTH = 4, WIDTH = 32).
module tb_ir_queue;
  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic CLK;
  logic RST_N;
  int   vectors;
  int   miscompares;

  ir_queue_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) irq ();

  ir_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .irq   (irq)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Apply one cycle of inputs, return 1 time unit after the rising edge with inputs idle.
  task automatic drive(input logic wre, input logic pop, input logic flush,
                       input logic [31:0] din, input logic inj);
    irq.IRWre         = wre;
    irq.IRPop         = pop;
    irq.IRFlush       = flush;
    irq.instructionIn = din;
`ifdef IR_PARITY_EN
    irq.irInjectErr   = inj;
`endif
    @(posedge CLK);
    #1;
    irq.IRWre   = 1'b0;
    irq.IRPop   = 1'b0;
    irq.IRFlush = 1'b0;
`ifdef IR_PARITY_EN
    irq.irInjectErr = 1'b0;
`endif
  endtask

  task automatic test_reset;
    #12;
    vectors++;
    if (irq.irCount !== 3'd0 || irq.irValid !== 1'b0 || irq.instructionOut !== 32'h0 ||
        irq.irFull !== 1'b0 || irq.pushDrop !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_init: cnt=%0d val=%b out=%h full=%b drop=%b, required 0 0 00000000 0 0",
               irq.irCount, irq.irValid, irq.instructionOut, irq.irFull, irq.pushDrop);
    end
    RST_N = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'hA1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'hA2, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'hA3, 1'b0);
    vectors++;
    if (irq.irCount !== 3'd3 || irq.instructionOut !== 32'hA1) begin
      miscompares++;
      $display("FAIL reset_prefill: cnt=%0d out=%h, required 3 000000a1", irq.irCount, irq.instructionOut);
    end
    #2 RST_N = 1'b0;
    #1;
    vectors++;
    if (irq.irCount !== 3'd0 || irq.irValid !== 1'b0 || irq.instructionOut !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_async: cnt=%0d val=%b out=%h, required 0 0 00000000",
               irq.irCount, irq.irValid, irq.instructionOut);
    end
    #3 RST_N = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_single_push;
    drive(1'b1, 1'b0, 1'b0, 32'h8C010004, 1'b0);
    vectors++;
    if (irq.irValid !== 1'b1 || irq.instructionOut !== 32'h8C010004 || irq.irCount !== 3'd1) begin
      miscompares++;
      $display("FAIL single_push: val=%b out=%h cnt=%0d, required 1 8c010004 1",
               irq.irValid, irq.instructionOut, irq.irCount);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (irq.irValid !== 1'b0 || irq.irCount !== 3'd0 || irq.instructionOut !== 32'h0) begin
      miscompares++;
      $display("FAIL single_pop: val=%b cnt=%0d out=%h, required 0 0 00000000",
               irq.irValid, irq.irCount, irq.instructionOut);
    end
  endtask

  task automatic test_fill_drop;
    logic [31:0] words [4];
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, words[i], 1'b0);
    vectors++;
    if (irq.irFull !== 1'b1 || irq.irCount !== 3'd4 || irq.instructionOut !== 32'h11) begin
      miscompares++;
      $display("FAIL fill: full=%b cnt=%0d out=%h, required 1 4 00000011",
               irq.irFull, irq.irCount, irq.instructionOut);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h55, 1'b0);
    vectors++;
    if (irq.pushDrop !== 1'b1 || irq.irCount !== 3'd4 || irq.instructionOut !== 32'h11) begin
      miscompares++;
      $display("FAIL drop_pulse: drop=%b cnt=%0d out=%h, required 1 4 00000011",
               irq.pushDrop, irq.irCount, irq.instructionOut);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (irq.pushDrop !== 1'b0) begin
      miscompares++;
      $display("FAIL drop_clear: drop=%b, required 0", irq.pushDrop);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (irq.instructionOut !== words[i] || irq.irCount !== CNT_W'(4 - i)) begin
        miscompares++;
        $display("FAIL drain_head%0d: out=%h cnt=%0d, required %h %0d",
                 i, irq.instructionOut, irq.irCount, words[i], 4 - i);
      end
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    end
    vectors++;
    if (irq.irValid !== 1'b0 || irq.irCount !== 3'd0 || irq.irFull !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_empty: val=%b cnt=%0d full=%b, required 0 0 0",
               irq.irValid, irq.irCount, irq.irFull);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] seq [14];
    seq[0] = 32'h11; seq[1] = 32'h22; seq[2] = 32'h33; seq[3] = 32'h44;
    for (int j = 0; j < 10; j++) seq[4 + j] = 32'h66 + 32'(j);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, seq[i], 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0, seq[4 + i], 1'b0);
      vectors++;
      if (irq.irCount !== 3'd4 || irq.irFull !== 1'b1 || irq.pushDrop !== 1'b0 ||
          irq.instructionOut !== seq[i + 1]) begin
        miscompares++;
        $display("FAIL b2b_cycle%0d: cnt=%0d full=%b drop=%b out=%h, required 4 1 0 %h",
                 i, irq.irCount, irq.irFull, irq.pushDrop, irq.instructionOut, seq[i + 1]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (irq.instructionOut !== seq[10 + i]) begin
        miscompares++;
        $display("FAIL b2b_drain%0d: out=%h, required %h", i, irq.instructionOut, seq[10 + i]);
      end
      drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    end
    vectors++;
    if (irq.irValid !== 1'b0 || irq.irCount !== 3'd0) begin
      miscompares++;
      $display("FAIL b2b_empty: val=%b cnt=%0d, required 0 0", irq.irValid, irq.irCount);
    end
  endtask

  task automatic test_flush;
    drive(1'b1, 1'b0, 1'b0, 32'hB1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'hB2, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 32'hDEAD, 1'b0);
    vectors++;
    if (irq.irCount !== 3'd0 || irq.irValid !== 1'b0 || irq.instructionOut !== 32'h0 ||
        irq.pushDrop !== 1'b0) begin
      miscompares++;
      $display("FAIL flush: cnt=%0d val=%b out=%h drop=%b, required 0 0 00000000 0",
               irq.irCount, irq.irValid, irq.instructionOut, irq.pushDrop);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h77, 1'b0);
    vectors++;
    if (irq.irCount !== 3'd1 || irq.instructionOut !== 32'h77) begin
      miscompares++;
      $display("FAIL flush_refill: cnt=%0d out=%h, required 1 00000077", irq.irCount, irq.instructionOut);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_pop_empty_push;
    drive(1'b1, 1'b1, 1'b0, 32'h99, 1'b0);
    vectors++;
    if (irq.irCount !== 3'd1 || irq.irValid !== 1'b1 || irq.instructionOut !== 32'h99) begin
      miscompares++;
      $display("FAIL pop_empty_push: cnt=%0d val=%b out=%h, required 1 1 00000099",
               irq.irCount, irq.irValid, irq.instructionOut);
    end
    drive(1'b1, 1'b1, 1'b0, 32'h9A, 1'b0);
    vectors++;
    if (irq.irCount !== 3'd1 || irq.instructionOut !== 32'h9A) begin
      miscompares++;
      $display("FAIL push_pop_one: cnt=%0d out=%h, required 1 0000009a", irq.irCount, irq.instructionOut);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (irq.irCount !== 3'd0 || irq.irValid !== 1'b0) begin
      miscompares++;
      $display("FAIL pop_on_empty: cnt=%0d val=%b, required 0 0", irq.irCount, irq.irValid);
    end
  endtask

`ifdef IR_PARITY_EN
  task automatic test_parity;
    drive(1'b1, 1'b0, 1'b0, 32'h00000001, 1'b1);
    vectors++;
    if (irq.irParityErr !== 1'b1) begin
      miscompares++;
      $display("FAIL parity_inject: err=%b, required 1", irq.irParityErr);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 32'h00000003, 1'b0);
    vectors++;
    if (irq.irParityErr !== 1'b0) begin
      miscompares++;
      $display("FAIL parity_clean: err=%b, required 0", irq.irParityErr);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h00000001, 1'b1);
    vectors++;
    if (irq.irParityErr !== 1'b0) begin
      miscompares++;
      $display("FAIL parity_behind: err=%b, required 0", irq.irParityErr);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (irq.irParityErr !== 1'b1 || irq.instructionOut !== 32'h1) begin
      miscompares++;
      $display("FAIL parity_head: err=%b out=%h, required 1 00000001", irq.irParityErr, irq.instructionOut);
    end
    drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    vectors++;
    if (irq.irParityErr !== 1'b0) begin
      miscompares++;
      $display("FAIL parity_empty: err=%b, required 0", irq.irParityErr);
    end
  endtask
`endif

  initial begin
    vectors           = 0;
    miscompares       = 0;
    RST_N             = 1'b0;
    irq.instructionIn = 32'h0;
    irq.IRWre         = 1'b0;
    irq.IRPop         = 1'b0;
    irq.IRFlush       = 1'b0;
`ifdef IR_PARITY_EN
    irq.irInjectErr   = 1'b0;
`endif
    test_reset();
    test_single_push();
    test_fill_drop();
    test_back_to_back();
    test_flush();
    test_pop_empty_push();
`ifdef IR_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
